// File: rtl/ref_sup_pkg.sv
// ref_sup_pkg: shared types and widths for the reference-clock supervisor.
//   sup_state_t : health FSM encoding (INIT/LOCK/DEGR/FAIL)
//   DEB_W       : debounce run-counter width
//   TDIV_W      : t1us-edge tick divider width
//   FDIV_W      : clk fallback tick divider width
package ref_sup_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOCK = 2'd1,
    ST_DEGR = 2'd2,
    ST_FAIL = 2'd3
  } sup_state_t;

  localparam int DEB_W  = 16;
  localparam int TDIV_W = 10;
  localparam int FDIV_W = 15;

endpackage

// File: rtl/ref_clk_supervisor_if.sv
// ref_clk_supervisor_if: bundle between the presence monitor / board logic
// and the supervisor.
//   master : drives err5_in, err64_in, t1us_in, alarm_clr; reads status
//   slave  : the supervisor side
// Optional macro ERR_COUNT_EN adds the cnt5/cnt64 fault-edge counters.
interface ref_clk_supervisor_if;
  logic       err5_in;
  logic       err64_in;
  logic       t1us_in;
  logic       alarm_clr;
  logic [1:0] state;
  logic       ref_ok;
  logic       fault5;
  logic       fault64;
  logic       alarm;
  logic       tick_1ms;
  logic       tick_src;
`ifdef ERR_COUNT_EN
  logic [7:0] cnt5;
  logic [7:0] cnt64;
`endif

  modport master (
    output err5_in, err64_in, t1us_in, alarm_clr,
    input  state, ref_ok, fault5, fault64, alarm, tick_1ms, tick_src
`ifdef ERR_COUNT_EN
    , input cnt5, cnt64
`endif
  );

  modport slave (
    input  err5_in, err64_in, t1us_in, alarm_clr,
    output state, ref_ok, fault5, fault64, alarm, tick_1ms, tick_src
`ifdef ERR_COUNT_EN
    , output cnt5, cnt64
`endif
  );
endinterface

// File: rtl/ref_clk_supervisor_sync_edge.sv
// sync_edge: 2-FF synchroniser for an asynchronous level plus a registered
// one-clk rising-edge pulse.
//   clk, rst : clock, async active-high reset
//   d        : asynchronous input
//   q        : synchronised level
//   rise     : one-clk pulse, 3 clk after the input edge
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise
);
  logic r_s1, r_s2, r_s3, r_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  assign q    = r_s2;
  assign rise = r_rise;
endmodule

// File: rtl/ref_clk_supervisor.sv
// ref_clk_supervisor: debounces the f5/f64 presence-monitor error levels,
// tracks reference health (INIT/LOCK/DEGR/FAIL), keeps a sticky alarm and
// emits a 1 ms tick from t1us edges (f64 healthy) or a clk divider.
//   clk, rst : 20 MHz clock, async active-high reset
//   sup      : ref_clk_supervisor_if.slave (inputs err5/err64/t1us/alarm_clr,
//              outputs state/ref_ok/fault5/fault64/alarm/tick_1ms/tick_src)
// Optional macro ERR_COUNT_EN: saturating fault5/fault64 rising-edge counters
// on sup.cnt5 / sup.cnt64, cleared by alarm_clr.
module ref_clk_supervisor
  import ref_sup_pkg::*;
#(
  parameter int DEB_CYC      = 1024,
  parameter int WARMUP_CYC   = 4096,
  parameter int TICK_DIV     = 1000,
  parameter int FALLBACK_DIV = 20000
) (
  input logic clk,
  input logic rst,
  ref_clk_supervisor_if.slave sup
);
  localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;

  // bit 0 = f5, bit 1 = f64
  logic [1:0]            w_raw_in;
  logic [1:0]            r_raw, r_qual;
  logic [1:0][DEB_W-1:0] r_deb_cnt;

  sup_state_t            r_state, w_nxt;
  logic [WARM_W-1:0]     r_warm;
  logic                  w_in_init, w_f5, w_f64, w_enter_bad;
  logic                  r_alarm;

  logic                  w_t1us_sync_unused, w_rise;
  logic                  w_src, r_src_q, w_chg;
  logic [TDIV_W-1:0]     r_tdiv;
  logic [FDIV_W-1:0]     r_fdiv;
  logic                  r_tick;

  assign w_raw_in = {sup.err64_in, sup.err5_in};

  // Debounce: run counter only advances while the registered raw level
  // disagrees with the qualified flag; any agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raw     <= '0;
      r_qual    <= '0;
      r_deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_raw[i] <= w_raw_in[i];
        if (r_raw[i] == r_qual[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_W'(DEB_CYC - 1)) begin
          r_qual[i]    <= r_raw[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Health FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_warm  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_INIT && r_warm != WARM_W'(WARMUP_CYC - 1))
        r_warm <= r_warm + 1'b1;
    end
  end

  // Health FSM: next state. Outside INIT the target depends only on the
  // qualified flags, so any state reaches any other in one step.
  always_comb begin
    w_nxt = r_state;
    if (r_state != ST_INIT || r_warm == WARM_W'(WARMUP_CYC - 1)) begin
      case (r_qual)
        2'b00:   w_nxt = ST_LOCK;
        2'b11:   w_nxt = ST_FAIL;
        default: w_nxt = ST_DEGR;
      endcase
    end
    w_enter_bad = (w_nxt != r_state) && (w_nxt == ST_DEGR || w_nxt == ST_FAIL);
  end

  assign w_in_init = (r_state == ST_INIT);
  assign w_f5      = r_qual[0] & ~w_in_init;
  assign w_f64     = r_qual[1] & ~w_in_init;

  // Alarm is edge-set (state entry), so a clear while still bad sticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_alarm <= 1'b0;
    else if (w_enter_bad)   r_alarm <= 1'b1;
    else if (sup.alarm_clr) r_alarm <= 1'b0;
  end

  sync_edge u_t1us (
    .clk  (clk),
    .rst  (rst),
    .d    (sup.t1us_in),
    .q    (w_t1us_sync_unused),
    .rise (w_rise)
  );

  // Tick source select; a change restarts both dividers and suppresses
  // the tick for that cycle.
  assign w_src = w_f64 | w_in_init;
  assign w_chg = w_src ^ r_src_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src_q <= 1'b1;
      r_tdiv  <= '0;
      r_fdiv  <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_src_q <= w_src;
      r_tick  <= 1'b0;

      if (w_chg || w_src) begin
        r_tdiv <= '0;
      end else if (w_rise) begin
        if (r_tdiv == TDIV_W'(TICK_DIV - 1)) begin
          r_tdiv <= '0;
          r_tick <= 1'b1;
        end else begin
          r_tdiv <= r_tdiv + 1'b1;
        end
      end

      if (w_chg || !w_src) begin
        r_fdiv <= '0;
      end else if (r_fdiv == FDIV_W'(FALLBACK_DIV - 1)) begin
        r_fdiv <= '0;
        r_tick <= 1'b1;
      end else begin
        r_fdiv <= r_fdiv + 1'b1;
      end
    end
  end

`ifdef ERR_COUNT_EN
  logic [1:0]      r_fault_d;
  logic [1:0]      w_fault_rise;
  logic [1:0][7:0] r_cnt;

  assign w_fault_rise = {w_f64, w_f5} & ~r_fault_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault_d <= '0;
      r_cnt     <= '0;
    end else begin
      r_fault_d <= {w_f64, w_f5};
      for (int i = 0; i < 2; i++) begin
        if (sup.alarm_clr)
          r_cnt[i] <= '0;
        else if (w_fault_rise[i] && r_cnt[i] != 8'hFF)
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  assign sup.cnt5  = r_cnt[0];
  assign sup.cnt64 = r_cnt[1];
`endif

  assign sup.state    = r_state;
  assign sup.ref_ok   = (r_state == ST_LOCK);
  assign sup.fault5   = w_f5;
  assign sup.fault64  = w_f64;
  assign sup.alarm    = r_alarm;
  assign sup.tick_1ms = r_tick;
  assign sup.tick_src = w_src;
endmodule

// File: tb/tb_ref_clk_supervisor.sv
// Bench for ref_clk_supervisor with DEB_CYC=16, WARMUP_CYC=32, TICK_DIV=10,
// FALLBACK_DIV=200; 20 MHz clk, 1 MHz t1us. Define ERR_COUNT_EN to also
// exercise the fault-edge counters.
module tb_ref_clk_supervisor;
  logic clk, rst;
  int   n_pass = 0, n_tot = 0;

  ref_clk_supervisor_if sup_if();

  ref_clk_supervisor #(
    .DEB_CYC(16), .WARMUP_CYC(32), .TICK_DIV(10), .FALLBACK_DIV(200)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sup (sup_if)
  );

  initial begin
    clk = 1'b0;
    forever #25 clk = ~clk;
  end

  initial begin
    sup_if.t1us_in = 1'b0;
    #7;
    forever #500 sup_if.t1us_in = ~sup_if.t1us_in;
  end

  typedef struct {
    string      name;
    int         ncyc;
    logic       e5, e64, clr;
    logic [1:0] st;
    logic       ok, f5, f64, al, src;
  } vec_t;

  vec_t tbl[13];
  vec_t exp_q[$];

  function automatic vec_t mk(string n, int c, logic e5, logic e64, logic clr,
                              logic [1:0] st, logic ok, logic f5, logic f64,
                              logic al, logic src);
    vec_t v;
    v.name = n; v.ncyc = c; v.e5 = e5; v.e64 = e64; v.clr = clr;
    v.st = st; v.ok = ok; v.f5 = f5; v.f64 = f64; v.al = al; v.src = src;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic cyc_to_lock(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (sup_if.state == 2'd0 && n < 200);
  endtask

  task automatic cyc_to_tick(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!sup_if.tick_1ms && n < 1000);
  endtask

  task automatic pulse_clr();
    sup_if.alarm_clr = 1'b1;
    @(negedge clk);
    sup_if.alarm_clr = 1'b0;
  endtask

  initial begin
    int   n;
    vec_t v, e;

    tbl[0]  = mk("idle_lock",    2,  0, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[1]  = mk("glitch5_on",   10, 1, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[2]  = mk("glitch5_off",  20, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[3]  = mk("err64_degr",   20, 0, 1, 0, 2'd2, 0, 0, 1, 1, 1);
    tbl[4]  = mk("both_fail",    20, 1, 1, 0, 2'd3, 0, 1, 1, 1, 1);
    tbl[5]  = mk("clr_in_fail",  5,  1, 1, 1, 2'd3, 0, 1, 1, 0, 1);
    tbl[6]  = mk("hold_fail",    20, 1, 1, 0, 2'd3, 0, 1, 1, 0, 1);
    tbl[7]  = mk("recover",      20, 0, 0, 0, 2'd1, 1, 0, 0, 0, 0);
    tbl[8]  = mk("err5_degr",    20, 1, 0, 0, 2'd2, 0, 1, 0, 1, 0);
    tbl[9]  = mk("sticky",       20, 0, 0, 0, 2'd1, 1, 0, 0, 1, 0);
    tbl[10] = mk("clr_lock",     3,  0, 0, 1, 2'd1, 1, 0, 0, 0, 0);
    tbl[11] = mk("lock_to_fail", 20, 1, 1, 0, 2'd3, 0, 1, 1, 1, 1);
    tbl[12] = mk("fail_to_lock", 20, 0, 0, 0, 2'd1, 1, 0, 0, 1, 0);

    // Reset values
    rst = 1'b1;
    sup_if.err5_in = 1'b0; sup_if.err64_in = 1'b0; sup_if.alarm_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.state", sup_if.state, 0);
    chk("rst.ref_ok", sup_if.ref_ok, 0);
    chk("rst.fault5", sup_if.fault5, 0);
    chk("rst.fault64", sup_if.fault64, 0);
    chk("rst.alarm", sup_if.alarm, 0);
    chk("rst.tick", sup_if.tick_1ms, 0);
    chk("rst.tick_src", sup_if.tick_src, 1);

    // Warm-up length, then LOCK on t1us ticks
    rst = 1'b0;
    cyc_to_lock(n);
    chk("warmup_cycles", n, 32);
    chk("lock.ref_ok", sup_if.ref_ok, 1);
    chk("lock.tick_src", sup_if.tick_src, 0);
    cyc_to_tick(n);
    cyc_to_tick(n);
    chk("t1us_tick_period", n, 200);
    @(negedge clk);

    // Table: push expectation when driving, pop when sampling
    for (int i = 0; i < 13; i++) begin
      v = tbl[i];
      sup_if.err5_in  = v.e5;
      sup_if.err64_in = v.e64;
      exp_q.push_back(v);
      if (v.clr) pulse_clr();
      else @(negedge clk);
      repeat (v.ncyc - 1) @(negedge clk);
      e = exp_q.pop_front();
      chk({e.name, ".state"},    sup_if.state,    e.st);
      chk({e.name, ".ref_ok"},   sup_if.ref_ok,   e.ok);
      chk({e.name, ".fault5"},   sup_if.fault5,   e.f5);
      chk({e.name, ".fault64"},  sup_if.fault64,  e.f64);
      chk({e.name, ".alarm"},    sup_if.alarm,    e.al);
      chk({e.name, ".tick_src"}, sup_if.tick_src, e.src);
    end

    // Fallback tick timing after source switch
    sup_if.err64_in = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!sup_if.tick_src && n < 60);
    chk("switch_seen", sup_if.tick_src, 1);
    cyc_to_tick(n);
    chk("first_fallback_tick_200_201", (n >= 200 && n <= 201) ? 1 : 0, 1);
    cyc_to_tick(n);
    chk("fallback_tick_period", n, 200);
    chk("fallback.state", sup_if.state, 2);
    @(negedge clk);
    sup_if.err64_in = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (sup_if.state != 2'd1 && n < 60);
    chk("back_to_lock.tick_src", sup_if.tick_src, 0);

    // alarm_clr coincident with DEGR entry: set wins
    @(negedge clk);
    pulse_clr();
    chk("pre_degr.alarm", sup_if.alarm, 0);
    sup_if.err64_in = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!sup_if.fault64 && n < 40);
    chk("entry_cycle.state", sup_if.state, 1);
    pulse_clr();
    chk("set_wins.state", sup_if.state, 2);
    chk("set_wins.alarm", sup_if.alarm, 1);
    pulse_clr();
    repeat (10) @(negedge clk);
    chk("clr_in_degr.alarm", sup_if.alarm, 0);

    // Async reset mid-DEGR, no clock edge needed
    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    chk("async.state", sup_if.state, 0);
    chk("async.fault64", sup_if.fault64, 0);
    chk("async.tick_src", sup_if.tick_src, 1);
    chk("async.ref_ok", sup_if.ref_ok, 0);
    chk("async.tick", sup_if.tick_1ms, 0);
    @(negedge clk);
    sup_if.err64_in = 1'b0;
    rst = 1'b0;
    cyc_to_lock(n);
    chk("rewarm_cycles", n, 32);
    chk("rewarm.alarm", sup_if.alarm, 0);
    @(negedge clk);

`ifdef ERR_COUNT_EN
    pulse_clr();
    chk("cnt5_start", sup_if.cnt5, 0);
    for (int k = 0; k < 300; k++) begin
      sup_if.err5_in = 1'b1;
      repeat (20) @(negedge clk);
      sup_if.err5_in = 1'b0;
      repeat (20) @(negedge clk);
    end
    chk("cnt5_sat", sup_if.cnt5, 255);
    chk("cnt64_idle", sup_if.cnt64, 0);
    pulse_clr();
    chk("cnt5_clr", sup_if.cnt5, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
